// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline definitions: result-select encoding and architectural register indices.
package writeback_regfile_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_RSV = 2'b11
    } res_src_e;

    localparam int unsigned REG_ZERO     = 0;
    localparam int unsigned REG_A0       = 10;
    localparam int unsigned RETIRE_WIDTH = 32;

endpackage

// File: rtl/writeback_regfile_result_mux.sv
// Writeback result select; also reused by forwarding logic as the EX bypass source.
module result_mux
    import writeback_regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] read_data,
    input  logic [WIDTH-1:0] pc_plus4,
    input  res_src_e         result_src,
    output logic [WIDTH-1:0] result_c
);

    // Reserved encoding yields zero so a stray select can never leak stale data.
    always_comb begin
        result_c = '0;
        case (result_src)
            RES_ALU: result_c = alu_result;
            RES_MEM: result_c = read_data;
            RES_PC4: result_c = pc_plus4;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus architectural register file with write-through reads and retire counter.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    ALUResultW,
    input  logic [DATA_WIDTH-1:0]    ReadDataW,
    input  logic [DATA_WIDTH-1:0]    PCPlus4W,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcW,
    input  logic                     ValidW,
    input  logic [ADDRESS_WIDTH-1:0] A1,
    input  logic [ADDRESS_WIDTH-1:0] A2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic [DATA_WIDTH-1:0]    ResultW,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic [RETIRE_WIDTH-1:0]  RetireCount
);

    localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [RETIRE_WIDTH-1:0] retire_q;
    logic                    wr_en_c;

    result_mux #(
        .WIDTH (DATA_WIDTH)
    ) u_result_mux (
        .alu_result (ALUResultW),
        .read_data  (ReadDataW),
        .pc_plus4   (PCPlus4W),
        .result_src (res_src_e'(ResultSrcW)),
        .result_c   (ResultW)
    );

    assign wr_en_c = RegWriteW && ValidW && (RdW != ADDRESS_WIDTH'(REG_ZERO));

    // Register array and retire counter; reset clears everything and drops a coincident write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            retire_q <= '0;
        end else begin
            if (wr_en_c) begin
                regs[RdW] <= ResultW;
            end
            if (ValidW) begin
                retire_q <= retire_q + RETIRE_WIDTH'(1);
            end
        end
    end

    // Read port 1: x0 and reset force zero, otherwise a pending write is bypassed to decode.
    always_comb begin
        RD1 = regs[A1];
        if (rst || (A1 == ADDRESS_WIDTH'(REG_ZERO))) begin
            RD1 = '0;
        end else if (wr_en_c && (RdW == A1)) begin
            RD1 = ResultW;
        end
    end

    // Read port 2 mirrors port 1 so equal indices always return equal data.
    always_comb begin
        RD2 = regs[A2];
        if (rst || (A2 == ADDRESS_WIDTH'(REG_ZERO))) begin
            RD2 = '0;
        end else if (wr_en_c && (RdW == A2)) begin
            RD2 = ResultW;
        end
    end

    // Debug view of x10 shows committed state only, never the bypass.
    assign a0          = regs[ADDRESS_WIDTH'(REG_A0)];
    assign RetireCount = retire_q;

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the datapath width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, the register index width (2^ADDRESS_WIDTH registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port ALUResultW, input, DATA_WIDTH, the ALU result from the MEM/WB register.
REQ-006 SHALL have port ReadDataW, input, DATA_WIDTH, the load data from the MEM/WB register.
REQ-007 SHALL have port PCPlus4W, input, DATA_WIDTH, the link value from the MEM/WB register.
REQ-008 SHALL have port RdW, input, ADDRESS_WIDTH, the destination register index.
REQ-009 SHALL have port RegWriteW, input, 1, the register write enable.
REQ-010 SHALL have port ResultSrcW, input, 2, the result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
REQ-011 SHALL have port ValidW, input, 1, set when the WB slot holds a real (non-bubble) instruction.
REQ-012 SHALL have ports A1 and A2, input, ADDRESS_WIDTH each, the decode-stage read indices.
REQ-013 SHALL have ports RD1 and RD2, output, DATA_WIDTH each, the read data for A1 and A2.
REQ-014 SHALL have port ResultW, output, DATA_WIDTH, the selected writeback value (forwarding source for EX).
REQ-015 SHALL have port a0, output, DATA_WIDTH, the live content of register x10 for debug.
REQ-016 SHALL have port RetireCount, output, 32, the count of retired instructions.

Function
REQ-017 ResultW SHALL be combinational: ALUResultW for 00, ReadDataW for 01, PCPlus4W for 10, and zero for 11.
REQ-018 A write SHALL occur at the rising clk edge iff RegWriteW=1, ValidW=1 and RdW!=0; register[RdW] takes ResultW.
REQ-019 Register x0 SHALL always read zero; writes to x0 SHALL be discarded without error.
REQ-020 RD1 and RD2 SHALL be combinational reads of the register array.
REQ-021 Same-cycle write/read: if a qualifying write targets An (An!=0), RDn SHALL return ResultW (write-through), so decode sees the value with zero added latency.
REQ-022 Both read ports reading the same index SHALL return identical data, including during write-through.
REQ-023 a0 SHALL reflect register x10 after the edge and SHALL NOT apply write-through.
REQ-024 RetireCount SHALL increment by 1 on each edge where ValidW=1, regardless of RegWriteW; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 ResultSrcW=11 with a qualifying write SHALL write zero to register[RdW].

Reset
REQ-026 While rst=1, all registers, a0 and RetireCount SHALL be zero immediately, without waiting for clk.
REQ-027 A write coinciding with reset assertion SHALL be lost; reset wins.
REQ-028 While rst=1, RD1 and RD2 SHALL read zero, with write-through suppressed.
REQ-029 The first write SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-030 A shared pipeline package SHALL hold the ResultSrc encoding enum (RES_ALU, RES_MEM, RES_PC4) and the constants REG_ZERO=0 and REG_A0=10.
REQ-031 The result mux SHALL be a separate sub-module, result_mux, for reuse by the hazard/forwarding logic.
REQ-032 The register array SHALL be in this module; no memory macro.

Verification
REQ-033 Assert rst mid-operation after writing x5=0x1234 -> RD1(A1=5)=0 and RetireCount=0 immediately, before any clk edge.
REQ-034 RegWriteW=1, ValidW=1, RdW=0, ALUResultW=0xDEADBEEF, then A1=0 -> RD1=0.
REQ-035 Same cycle: RdW=7, ResultSrcW=01, ReadDataW=0xCAFEF00D, A1=A2=7 -> RD1=RD2=0xCAFEF00D before the edge; still 0xCAFEF00D after it.
REQ-036 ResultSrcW=10, PCPlus4W=0x104, RdW=1 (JAL) -> x1=0x104; with RdW=10 -> a0=0x104 after the edge.
REQ-037 ValidW=0 with RegWriteW=1, RdW=3 -> x3 unchanged and RetireCount unchanged.
REQ-038 Preload RetireCount near wrap (force 0xFFFFFFFF), one valid cycle -> RetireCount=0.
